dac_sample_tx: RTL and testbench
================================

// Module: dac_sample_tx
// PURPOSE
//  Transmit side of the HSMC data-converter path: accepts paired channel A/B samples on a valid/ready stream,
//  buffers them in a small FIFO, and drives registered 14-bit codes to the DA/DB DAC buses at sys_clk.
//  Prime/run/underflow control keeps the DAC output continuous.
//  Sits between the DSP/filter datapath and the top-level DA/DB pins.
// PARAMETERS
//  DATA_W      14       bits per channel sample
//  FIFO_DEPTH  16       FIFO entries (power of 2, >=4)
//  PRIME_LEVEL 8        FIFO level required to enter RUN (1..FIFO_DEPTH)
//  IDLE_CODE   14'h2000 offset-binary mid-scale code driven when not running
// PORTS
//  sys_clk      in   1          single clock; all logic rising-edge
//  reset        in   1          synchronous, active-high
//  s_data       in   2*DATA_W   {chB, chA} sample pair
//  s_valid      in   1          s_data valid
//  s_ready      out  1          transfer on s_valid && s_ready at rising edge
//  enable       in   1          1 = stream active; 0 = idle and flush
//  pause        in   1          in RUN: hold outputs, no FIFO pop
//  fmt_twos     in   1          1 = input is two's complement, convert to offset binary
//  dac_da       out  DATA_W     channel A DAC code (registered)
//  dac_db       out  DATA_W     channel B DAC code (registered)
//  running      out  1          state == RUN
//  fifo_level   out  $clog2(FIFO_DEPTH)+1   current FIFO occupancy
//  underflow_cnt out 16         saturating underflow event count
// BEHAVIOUR
//  Reset: dac_da = dac_db = IDLE_CODE; s_ready = 0; running = 0; fifo_level = 0; underflow_cnt = 0; state IDLE.
//  s_ready = enable && (state != IDLE) && !full. At full, no push even if a pop occurs in the same cycle.
//  FSM: IDLE -> PRIME when enable=1 (one cycle in IDLE; s_ready rises the cycle after enable).
//   PRIME: accept only. Outputs hold their last value. Go to RUN at the edge where level after write >= PRIME_LEVEL.
//   RUN: each cycle with !pause and FIFO non-empty, pop the head (show-ahead) and register it onto dac_da/dac_db.
//    The first pop occurs on the cycle after entering RUN.
//   RUN with !pause and FIFO empty: outputs hold the last sample; underflow_cnt += 1 (saturates at 16'hFFFF);
//    go to PRIME.
//   Any state with enable=0: next edge -> IDLE; FIFO flushed; dac_da = dac_db = IDLE_CODE; underflow_cnt unchanged.
//  Simultaneous push and pop: both take effect; level unchanged.
//  Format conversion at the output register: fmt_twos=1 -> code = {~d[DATA_W-1], d[DATA_W-2:0]}; else code = d.
//   fmt_twos is sampled per pop.
//  Latency: a sample written at edge k (non-empty RUN, no pause) reaches the pins no earlier than edge k+1.
//   Ordering is strictly FIFO.
//  Reset mid-operation overrides everything in the same edge.
// CONFIGURATION
//  DAC_TEST_PATTERN_EN defined: adds input pattern_en.
//   When pattern_en=1 and state RUN: FIFO bypassed (no pop, no underflow counting); s_ready=0;
//    dac_da = 14-bit sawtooth incrementing by 1 per cycle, starting at 0 on pattern_en rise; dac_db = ~dac_da.
//   Deassert: resume normal RUN from the FIFO.
//  DAC_TEST_PATTERN_EN undefined: port absent; behaviour identical to pattern_en=0.
// STRUCTURE
//  Package dac_tx_pkg: state enum (IDLE, PRIME, RUN); DATA_W and IDLE_CODE defaults;
//   function to_offset_bin(d, fmt_twos).
//  Sub-module dac_tx_fifo: synchronous show-ahead FIFO (push, pop, flush, full, empty, level).
//  dac_sample_tx holds the FSM, format conversion, output registers and counter.
// TESTING
//  1 Reset held 3 cycles -> dac_da=dac_db=14'h2000, s_ready=0, underflow_cnt=0, running=0.
//  2 enable=1, fmt_twos=0, push {B=100+k, A=k}, k=0..7 back-to-back -> running=1 after 8th write;
//    dac_da = 0..7 and dac_db = 100..107 on consecutive cycles.
//  3 Stream from test 2 stops -> dac_da holds 7, underflow_cnt=1, state PRIME, s_ready=1; 8 more pushes resume RUN.
//  4 pause=1 in RUN, push 16 words -> fifo_level=16, s_ready=0, 17th word held;
//    pause=0 -> 16 words out in order, then the 17th.
//  5 fmt_twos=1: A=14'h0000 -> dac_da=14'h2000; A=14'h3FFF -> 14'h1FFF; A=14'h1FFF -> 14'h3FFF.
//  6 enable=0 in RUN with 5 queued -> next edge dac_da=dac_db=14'h2000, fifo_level=0, running=0,
//    underflow_cnt unchanged; reset asserted mid-RUN -> all reset values.

Source files
------------

// File: rtl/dac_tx_pkg.sv
// Shared definitions for the DAC transmit path.
//   tx_state_e     : control state (IDLE, PRIME, RUN)
//   DAC_DATA_W     : default bits per channel sample
//   DAC_IDLE_CODE  : offset-binary mid-scale code driven while not running
//   to_offset_bin  : converts a two's complement sample to offset binary when
//                    fmt_twos is set, otherwise passes the sample through
package dac_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } tx_state_e;

  localparam int DAC_DATA_W = 14;
  localparam logic [DAC_DATA_W-1:0] DAC_IDLE_CODE = 14'h2000;

  // Two's complement to offset binary is an inversion of the sign bit.
  function automatic logic [DAC_DATA_W-1:0] to_offset_bin(
    input logic [DAC_DATA_W-1:0] d,
    input logic                  fmt_twos
  );
    return fmt_twos ? {~d[DAC_DATA_W-1], d[DAC_DATA_W-2:0]} : d;
  endfunction

endpackage

// File: rtl/dac_tx_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on rdata whenever
// empty is low, and pop advances past it at the clock edge.
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   flush             : synchronous clear of all entries
//   push, wdata       : write request and data (ignored while full)
//   pop               : read request (ignored while empty)
//   rdata             : head entry
//   full, empty       : occupancy flags
//   level             : current number of entries
module dac_tx_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a write even when a read frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == LW'(DEPTH));
  assign empty = (count == '0);
  assign level = count;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/dac_sample_tx.sv
// DAC sample transmitter: accepts {chB, chA} sample pairs on a valid/ready
// stream, buffers them in a show-ahead FIFO and drives registered codes onto
// the DA/DB DAC buses. A prime/run/underflow controller keeps the DAC output
// continuous: it waits for PRIME_LEVEL entries before streaming, and on
// running dry holds the last sample, counts the event and re-primes.
// Optional feature macro: DAC_TEST_PATTERN_EN adds input pattern_en, which in
// RUN replaces the FIFO stream with a sawtooth on dac_da and its complement
// on dac_db.
// Ports:
//   sys_clk, reset     : clock and synchronous active-high reset
//   s_data, s_valid    : sample pair {chB, chA} and its valid flag
//   s_ready            : sink ready
//   enable             : 1 = stream active, 0 = idle and flush
//   pause              : in RUN, hold outputs and do not consume
//   fmt_twos           : input samples are two's complement
//   pattern_en         : test pattern select (only with DAC_TEST_PATTERN_EN)
//   dac_da, dac_db     : registered DAC codes for channels A and B
//   running            : controller is in RUN
//   fifo_level         : FIFO occupancy
//   underflow_cnt      : saturating count of underflow events
//   fsm_state          : controller state, for observation
//
// Handshake: a sample transfers at the rising edge where s_valid && s_ready.
// s_valid may be raised at any time; s_ready depends only on enable, state
// and FIFO fullness (and pattern mode), never on s_valid.
module dac_sample_tx
  import dac_tx_pkg::*;
#(
  parameter int                DATA_W      = DAC_DATA_W,
  parameter int                FIFO_DEPTH  = 16,
  parameter int                PRIME_LEVEL = 8,
  parameter logic [DATA_W-1:0] IDLE_CODE   = DAC_IDLE_CODE
) (
  input  logic                          sys_clk,
  input  logic                          reset,
  input  logic [2*DATA_W-1:0]           s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          enable,
  input  logic                          pause,
  input  logic                          fmt_twos,
`ifdef DAC_TEST_PATTERN_EN
  input  logic                          pattern_en,
`endif
  output logic [DATA_W-1:0]             dac_da,
  output logic [DATA_W-1:0]             dac_db,
  output logic                          running,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   underflow_cnt,
  output logic [1:0]                    fsm_state
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME_LEVEL);

  tx_state_e           state;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                flush;
  logic                pat_active;
  logic [2*DATA_W-1:0] head;
  logic [LW-1:0]       level_after_write;

`ifdef DAC_TEST_PATTERN_EN
  logic [DATA_W-1:0]   pat_cnt;
  assign pat_active = pattern_en && (state == RUN);
`else
  assign pat_active = 1'b0;
`endif

  assign s_ready = enable && (state != IDLE) && !full && !pat_active;
  assign push    = s_valid && s_ready;
  assign pop     = enable && (state == RUN) && !pause && !empty && !pat_active;
  assign flush   = !enable;

  // PRIME never pops, so the post-write level is the current level plus the push.
  assign level_after_write = fifo_level + LW'(push);

  assign running   = (state == RUN);
  assign fsm_state = state;

  dac_tx_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .wdata (s_data),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state         <= IDLE;
      dac_da        <= IDLE_CODE;
      dac_db        <= IDLE_CODE;
      underflow_cnt <= '0;
    end else if (!enable) begin
      state  <= IDLE;
      dac_da <= IDLE_CODE;
      dac_db <= IDLE_CODE;
    end else begin
      case (state)
        IDLE: begin
          state <= PRIME;
        end
        PRIME: begin
          if (level_after_write >= PRIME_LVL) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (pat_active) begin
`ifdef DAC_TEST_PATTERN_EN
            dac_da <= pat_cnt;
            dac_db <= ~pat_cnt;
`endif
          end else if (!pause) begin
            if (!empty) begin
              dac_da <= to_offset_bin(head[DATA_W-1:0], fmt_twos);
              dac_db <= to_offset_bin(head[2*DATA_W-1:DATA_W], fmt_twos);
            end else begin
              // Ran dry: hold the last sample and re-prime.
              if (underflow_cnt != 16'hFFFF) begin
                underflow_cnt <= underflow_cnt + 16'd1;
              end
              state <= PRIME;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef DAC_TEST_PATTERN_EN
  // Sawtooth restarts from zero whenever the pattern is deselected.
  always_ff @(posedge sys_clk) begin
    if (reset || !pattern_en) begin
      pat_cnt <= '0;
    end else if (pat_active && enable) begin
      pat_cnt <= pat_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dac_sample_tx.sv
// Testbench for dac_sample_tx: directed stimulus, a queue-based reference
// model checked every cycle, plus hand-computed literal expectations.
module tb_dac_sample_tx;

  localparam int DW = 14;
  localparam int W  = 2 * DW;

  logic          sys_clk = 1'b0;
  logic          reset   = 1'b1;
  logic [W-1:0]  s_data  = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          enable  = 1'b0;
  logic          pause   = 1'b0;
  logic          fmt_twos = 1'b0;
  logic [DW-1:0] dac_da;
  logic [DW-1:0] dac_db;
  logic          running;
  logic [4:0]    fifo_level;
  logic [15:0]   underflow_cnt;
  logic [1:0]    fsm_state;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // ---------------- clock ----------------
  always #5 sys_clk = ~sys_clk;

  dac_sample_tx dut (
    .sys_clk       (sys_clk),
    .reset         (reset),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .enable        (enable),
    .pause         (pause),
    .fmt_twos      (fmt_twos),
`ifdef DAC_TEST_PATTERN_EN
    .pattern_en    (1'b0),
`endif
    .dac_da        (dac_da),
    .dac_db        (dac_db),
    .running       (running),
    .fifo_level    (fifo_level),
    .underflow_cnt (underflow_cnt),
    .fsm_state     (fsm_state)
  );

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 priming, 2 running. exp_q holds queued sample pairs.
  logic [W-1:0]  exp_q[$];
  int            m_mode = 0;
  logic [DW-1:0] m_da   = 14'h2000;
  logic [DW-1:0] m_db   = 14'h2000;
  logic [15:0]   m_ucnt = 16'd0;

  function automatic logic [DW-1:0] model_code(input logic [DW-1:0] d, input logic twos);
    return twos ? (d ^ 14'h2000) : d;
  endfunction

  function automatic logic model_ready();
    return enable && (m_mode != 0) && (exp_q.size() < 16);
  endfunction

  always @(posedge sys_clk) begin
    logic         do_push;
    logic [W-1:0] w;
    do_push = s_valid && model_ready();
    if (reset) begin
      m_mode = 0;
      exp_q.delete();
      m_da   = 14'h2000;
      m_db   = 14'h2000;
      m_ucnt = 16'd0;
    end else if (!enable) begin
      m_mode = 0;
      exp_q.delete();
      m_da   = 14'h2000;
      m_db   = 14'h2000;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (do_push) exp_q.push_back(s_data);
      if (exp_q.size() >= 8) m_mode = 2;
    end else begin
      if (!pause) begin
        if (exp_q.size() > 0) begin
          w    = exp_q.pop_front();
          m_da = model_code(w[DW-1:0], fmt_twos);
          m_db = model_code(w[W-1:DW], fmt_twos);
        end else begin
          if (m_ucnt != 16'hFFFF) m_ucnt = m_ucnt + 16'd1;
          m_mode = 1;
        end
      end
      if (do_push) exp_q.push_back(s_data);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (chk_en) begin
      check("cyc_dac_da",   32'(dac_da),        32'(m_da));
      check("cyc_dac_db",   32'(dac_db),        32'(m_db));
      check("cyc_s_ready",  32'(s_ready),       32'(model_ready()));
      check("cyc_running",  32'(running),       32'(m_mode == 2));
      check("cyc_level",    32'(fifo_level),    32'(exp_q.size()));
      check("cyc_underflow",32'(underflow_cnt), 32'(m_ucnt));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic push_word(input logic [DW-1:0] b, input logic [DW-1:0] a);
    logic rdy;
    int   guard;
    guard   = 0;
    s_valid = 1'b1;
    s_data  = {b, a};
    rdy     = 1'b0;
    while (!rdy && guard < 200) begin
      @(negedge sys_clk);
      rdy = s_ready;
      tick();
      guard++;
    end
    if (!rdy) begin
      n_cmp++;
      n_err++;
      $display("FAIL push_timeout at %0t: got no s_ready, expected s_ready within 200 cycles", $time);
    end
    s_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic rdy;
    tick();
    chk_en = 1'b1;
    repeat (2) tick();
    // Reset values after three reset cycles.
    check("rst_dac_da",  32'(dac_da),        32'h2000);
    check("rst_dac_db",  32'(dac_db),        32'h2000);
    check("rst_s_ready", 32'(s_ready),       32'd0);
    check("rst_ucnt",    32'(underflow_cnt), 32'd0);
    check("rst_running", 32'(running),       32'd0);
    reset = 1'b0;

    // Prime with eight pairs and stream them out.
    enable = 1'b1;
    for (int k = 0; k < 8; k++) push_word(14'(100 + k), 14'(k));
    check("prime_running", 32'(running), 32'd1);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("stream_da", 32'(dac_da), 32'(k));
      check("stream_db", 32'(dac_db), 32'(100 + k));
    end

    // Stream stops: underflow, hold last sample, re-prime.
    tick();
    check("uf_da_hold", 32'(dac_da),        32'd7);
    check("uf_cnt1",    32'(underflow_cnt), 32'd1);
    check("uf_state",   32'(fsm_state),     32'd1);
    check("uf_s_ready", 32'(s_ready),       32'd1);
    for (int k = 8; k < 16; k++) push_word(14'(100 + k), 14'(k));
    check("reprime_running", 32'(running), 32'd1);
    repeat (10) tick();
    check("drain2_da",  32'(dac_da),        32'd15);
    check("drain2_db",  32'(dac_db),        32'd115);
    check("uf_cnt2",    32'(underflow_cnt), 32'd2);

    // Paused fill to full, 17th word held back.
    pause = 1'b1;
    for (int i = 0; i < 16; i++) push_word(14'(14'h200 + i), 14'(14'h100 + i));
    s_valid = 1'b1;
    s_data  = {14'h0155, 14'h03AA};
    repeat (3) tick();
    check("full_level",   32'(fifo_level), 32'd16);
    check("full_s_ready", 32'(s_ready),    32'd0);
    pause = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge sys_clk);
      rdy = s_ready;
      tick();
      if (rdy) s_valid = 1'b0;
      check("order_da", 32'(dac_da), (i < 16) ? 32'(14'h100 + i) : 32'h3AA);
      check("order_db", 32'(dac_db), (i < 16) ? 32'(14'h200 + i) : 32'h155);
    end
    check("order_level", 32'(fifo_level), 32'd0);

    // Two's complement input conversion.
    fmt_twos = 1'b1;
    push_word(14'h0000, 14'h0000);
    push_word(14'h3FFF, 14'h3FFF);
    push_word(14'h1FFF, 14'h1FFF);
    for (int i = 0; i < 5; i++) push_word(14'(14'h10 + i), 14'(14'h10 + i));
    check("uf_cnt3", 32'(underflow_cnt), 32'd3);
    tick();
    check("twos_0000", 32'(dac_da), 32'h2000);
    tick();
    check("twos_3fff", 32'(dac_da), 32'h1FFF);
    tick();
    check("twos_1fff", 32'(dac_da), 32'h3FFF);
    check("twos_db",   32'(dac_db), 32'h3FFF);
    check("queued5",   32'(fifo_level), 32'd5);

    // Disable in RUN with five queued.
    enable   = 1'b0;
    fmt_twos = 1'b0;
    tick();
    check("dis_da",      32'(dac_da),        32'h2000);
    check("dis_db",      32'(dac_db),        32'h2000);
    check("dis_level",   32'(fifo_level),    32'd0);
    check("dis_running", 32'(running),       32'd0);
    check("dis_ucnt",    32'(underflow_cnt), 32'd3);

    // Reset mid-RUN.
    enable = 1'b1;
    for (int i = 0; i < 8; i++) push_word(14'(14'h0A00 + i), 14'(14'h0500 + i));
    repeat (2) tick();
    check("pre_rst_running", 32'(running), 32'd1);
    reset = 1'b1;
    tick();
    check("mrst_da",      32'(dac_da),        32'h2000);
    check("mrst_db",      32'(dac_db),        32'h2000);
    check("mrst_level",   32'(fifo_level),    32'd0);
    check("mrst_running", 32'(running),       32'd0);
    check("mrst_ucnt",    32'(underflow_cnt), 32'd0);
    check("mrst_s_ready", 32'(s_ready),       32'd0);
    reset  = 1'b0;
    enable = 1'b0;
    repeat (3) tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
